// File: rtl/mux_4_1_rr_ctrl_pkg.sv
// Shared constants and state encoding for the round-robin 4:1 mux sequencer.
// Channel count and select width are fixed by the 4:1 mux this block wraps.
package mux_ctrl_pkg;

    localparam int N_CH               = 4;
    localparam int SEL_W              = 2;
    localparam int BEAT_W             = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_BURST_LEN  = 1;

    // sel parks here while in reset; matches the reset value of last_grant
    localparam logic [SEL_W-1:0] PARK_SEL = 2'd3;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/mux_4_1_rr_ctrl_if.sv
// Handshake bundle between producers, the 4:1 data mux and the downstream consumer.
// The slave view is the sequencer; the master view is the surrounding fabric.
interface mux_4_1_rr_ctrl_if #(
    parameter int DATA_WIDTH = mux_ctrl_pkg::DEFAULT_DATA_WIDTH
);
    import mux_ctrl_pkg::*;

    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] mux_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [SEL_W-1:0]      out_ch;

    modport master (
        output in_valid, mux_out, out_ready,
        input  in_ready, sel, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, mux_out, out_ready,
        output in_ready, sel, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mux_4_1_rr_ctrl_rr_pick4.sv
// Combinational round-robin picker: first requesting channel after 'last', wrapping.
// With no request, pick stays on 'last' so the mux select does not toggle.
module rr_pick4
    import mux_ctrl_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        pick = last;
        any  = |req;
        for (int k = N_CH; k >= 1; k--) begin
            if (req[last + SEL_W'(k)]) begin
                pick = last + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_ctrl.sv
// Round-robin sequencer around a 4:1 data mux with a one-entry registered output.
//   state | meaning
//   ARB   | pick next requester after last_grant and load one beat if the slot is free
//   BURST | hold grant on last_grant for up to BURST_LEN beats; others ignored
module mux_4_1_rr_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
    input logic              clk,
    input logic              rst_n,
    mux_4_1_rr_ctrl_if.slave bus
);

    localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(BURST_LEN);

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      last_q, last_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [SEL_W-1:0]      pick;
    logic                  any;
    logic                  can_load;
    logic                  load;
    logic [SEL_W-1:0]      load_ch;
    logic [SEL_W-1:0]      sel_c;
    logic [N_CH-1:0]       ready_c;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0]      out_ch_q;

    rr_pick4 u_pick (
        .req  (bus.in_valid),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    assign can_load = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        sel_c   = last_q;
        ready_c = '0;
        load    = 1'b0;
        load_ch = last_q;
        case (state_q)
            ARB: begin
                if (can_load && any) begin
                    sel_c         = pick;
                    ready_c[pick] = 1'b1;
                    load          = 1'b1;
                    load_ch       = pick;
                    last_d        = pick;
                    beat_d        = BEAT_W'(1);
                    if (BURST_LEN > 1) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // A dropped request ends the burst without a transfer.
                if (!bus.in_valid[last_q]) begin
                    state_d = ARB;
                    beat_d  = '0;
                end else if (can_load) begin
                    ready_c[last_q] = 1'b1;
                    load            = 1'b1;
                    beat_d          = beat_q + BEAT_W'(1);
                    if (beat_q + BEAT_W'(1) == BURST_LAST) begin
                        state_d = ARB;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            last_q  <= PARK_SEL;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Load wins over drain so a simultaneous load/drain keeps full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.mux_out;
            out_ch_q    <= load_ch;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Handshake outputs are forced quiet while reset is held, independent of clk.
    assign bus.in_ready  = rst_n ? ready_c : '0;
    assign bus.sel       = rst_n ? sel_c : PARK_SEL;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: doc/mux_4_1_rr_ctrl.md
Name: mux_4_1_rr_ctrl

Overview:
- Sequencing stage wrapped around the 4:1 data mux (DATA_WIDTH-parameterised, 2-bit sel).
- Upstream side: arbitrates four valid/ready producer channels round-robin and drives the mux sel.
- Downstream side: registers the mux output into a one-entry output stage with a valid/ready handshake.
- Optional burst mode keeps a grant on one channel for up to BURST_LEN beats before rotating.

Parameters:
- DATA_WIDTH, 8: width of mux_out and out_data; legal values are 4, 8 and 16, matching the mux instances.
- BURST_LEN, 1: maximum consecutive accepted beats per grant; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-channel request; bit i belongs to mux input in<i>.
- in_ready  output  4  per-channel accept; at most one bit high, combinational.
- sel  output  2  mux select, combinational.
- mux_out  input  DATA_WIDTH  mux output, sampled in the same cycle as sel.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  registered data.
- out_ch  output  2  source channel of out_data.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, last_grant=3, beat_cnt=0, state=ARB. in_ready=0 and sel=3 while in reset.
- can_load = !out_valid | out_ready (output slot empty or being drained this cycle).
- State ARB:
  - pick = first set bit of in_valid, searching last_grant+1, +2, +3, +4 (mod 4).
  - If can_load and in_valid!=0: sel=pick, in_ready[pick]=1.
  - On the edge: out_data<=mux_out, out_ch<=pick, out_valid<=1, last_grant<=pick, beat_cnt<=1.
  - Then go to BURST if BURST_LEN>1, otherwise stay in ARB.
  - Otherwise: sel=last_grant, in_ready=0.
- State BURST (grant held on last_grant):
  - sel=last_grant.
  - If can_load and in_valid[last_grant]: in_ready[last_grant]=1, capture as above, beat_cnt++. When beat_cnt+1==BURST_LEN, return to ARB.
  - If in_valid[last_grant]=0: return to ARB with no transfer. Rotation starts from last_grant+1. beat_cnt clears.
  - Requests from other channels are ignored while in BURST.
- Output stage:
  - out_valid & out_ready & no new load: out_valid<=0, out_data holds its value.
  - Load and drain in the same cycle: full throughput, 1 beat/cycle, out_valid stays 1.
  - out_valid & !out_ready: in_ready=0 for all channels, out_data/out_ch stable. No data is dropped or overwritten.
- Latency: 1 cycle from in_valid&in_ready to out_valid.
- sel is valid only while in_ready!=0. When idle it parks on last_grant, so mux_out is quiet.
- All four in_valid high with BURST_LEN=1: grant sequence 0,1,2,3,0,… (first grant after reset is 0).
- in_valid may drop without a handshake; the arbiter re-evaluates every cycle in ARB.
- Reset asserted mid-burst: state, counter and out_valid clear immediately. Data in the output register is discarded.

Decomposition:
- Shared package mux_ctrl_pkg:
  - N_CH=4 and SEL_W=2.
  - State encoding ARB=1'b0, BURST=1'b1.
  - Default DATA_WIDTH.
- Sub-module rr_pick4: combinational, inputs req[3:0] and last[1:0], outputs pick[1:0] and any.
  - Instantiated once.
  - Unit-tested exhaustively over 64 combinations.

Test Plan:
- Reset check: rst_n=0 mid-transfer, asynchronously, no clk edge needed. Required: out_valid=0, in_ready=0, sel=3 immediately. Then in_valid=4'b0100, out_ready=1, release reset. Required: sel=2, in_ready=4'b0100, and next cycle out_data=in2 value, out_ch=2.
- Round robin, BURST_LEN=1, in_valid=4'b1111, out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 and one beat every cycle.
- Skip and wrap: last_grant=2, in_valid=4'b0011. Required: grant 0, then 1, then 0. Channel 3 is never granted.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b1111. Required: in_ready=0 and out_data constant. On out_ready=1 the same-cycle load occurs with out_valid staying 1.
- Burst, BURST_LEN=3, in_valid=4'b0011 steady. Required: out_ch 0,0,0,1,1,1,0. If ch0 drops after 1 beat, the next grant goes to ch1.
- Width sweep: DATA_WIDTH=4/8/16 with random in0..in3. Required: out_data equals the selected input truncated to DATA_WIDTH for 200 random beats, checked against a queue model.
